// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter that serialises multi-byte read/write requests from
// several requester ports onto a single external byte-wide memory bus.
//
// Ports:
//   clk_in, rst_in   system clock, synchronous active-high reset
//   rdy_in           global pause; all state frozen while low
//   port_req/_wr/_size/_addr/_wdata   per-port request bundle (packed by port)
//   flush_in         misprediction flush (aborts reads, blocks new reads)
//   io_buffer_full   UART transmit buffer full (stalls IO-region write bytes)
//   mem_din/mem_dout/mem_a/mem_wr     external byte bus (sync read, 1-cycle latency)
//   port_grant       one-hot acceptance pulse
//   port_done        one-hot completion pulse
//   rdata            read result, valid in the port_done cycle
//   dbg_state_o      current FSM state
//
// Handshake: a port holds port_req high with a stable request bundle until it
// sees port_grant; the bundle is captured at the accepting edge, so the port
// may change or drop it from the grant cycle onward. port_done marks the end
// of that port's transaction.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 32
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS-1:0]        port_wr,
  input  logic [2*NUM_PORTS-1:0]      port_size,
  input  logic [ADDR_W*NUM_PORTS-1:0] port_addr,
  input  logic [32*NUM_PORTS-1:0]     port_wdata,
  input  logic                        flush_in,
  input  logic                        io_buffer_full,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [31:0]                 mem_a,
  output logic                        mem_wr,
  output logic [NUM_PORTS-1:0]        port_grant,
  output logic [NUM_PORTS-1:0]        port_done,
  output logic [31:0]                 rdata,
  output logic [1:0]                  dbg_state_o
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  state_t               state_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        port_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [2:0]           n_q;        // transfer length in bytes (1, 2 or 4)
  logic [2:0]           k_q;        // next byte to issue
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic                 pend_v_q;   // a read byte was issued last active cycle
  logic [1:0]           pend_idx_q; // which byte that was
  logic                 rdy_prev_q; // rdy_in was high in the previous cycle
  logic [NUM_PORTS-1:0] grant_q;
  logic [NUM_PORTS-1:0] done_q;

  // Round-robin pick starting at ptr_q. A flush masks read requests only.
  logic [NUM_PORTS-1:0] eligible;
  logic                 pick_valid;
  logic [PW-1:0]        pick_idx;
  logic [PW:0]          cand;

  always_comb begin
    eligible   = port_req & ~(~port_wr & {NUM_PORTS{flush_in}});
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_PORTS)) cand = cand - (PW+1)'(NUM_PORTS);
      if (!pick_valid && eligible[cand[PW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end
  end

  logic [PW:0]       ptr_inc;
  logic [PW-1:0]     ptr_next;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [1:0]        sel_size;
  logic              sel_wr;
  logic [2:0]        sel_n;

  assign ptr_inc   = {1'b0, pick_idx} + (PW+1)'(1);
  assign ptr_next  = (ptr_inc == (PW+1)'(NUM_PORTS)) ? '0 : ptr_inc[PW-1:0];
  assign sel_addr  = port_addr[ADDR_W*int'(pick_idx) +: ADDR_W];
  assign sel_wdata = port_wdata[32*int'(pick_idx) +: 32];
  assign sel_size  = port_size[2*int'(pick_idx) +: 2];
  assign sel_wr    = port_wr[pick_idx];
  assign sel_n     = (sel_size == 2'b00) ? 3'd1 : (sel_size == 2'b01) ? 3'd2 : 3'd4;

  // Byte issue. After a pause the read byte whose data arrived during the
  // pause was never captured, so it goes out again before k_q advances.
  logic              reissue;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] cur_addr;
  logic              io_hold;
  logic              rd_issue;
  logic              wr_issue;

  assign reissue  = (state_q == READ) && pend_v_q && !rdy_prev_q;
  assign byte_idx = reissue ? pend_idx_q : k_q[1:0];
  assign cur_addr = addr_q + ADDR_W'(byte_idx);
  assign io_hold  = io_buffer_full && (cur_addr[17:16] == 2'b11);
  assign rd_issue = (state_q == READ) && rdy_in && !rst_in && !flush_in &&
                    (reissue || (k_q < n_q));
  assign wr_issue = (state_q == WRITE) && rdy_in && !rst_in && !io_hold;

  assign mem_wr      = wr_issue;
  assign mem_a       = (rd_issue || wr_issue) ? 32'(cur_addr) : '0;
  assign mem_dout    = wr_issue ? wdata_q[8*byte_idx +: 8] : '0;
  assign port_grant  = rdy_in ? grant_q : '0;
  assign port_done   = rdy_in ? done_q : '0;
  assign rdata       = rdata_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      port_q     <= '0;
      addr_q     <= '0;
      n_q        <= '0;
      k_q        <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      pend_v_q   <= 1'b0;
      pend_idx_q <= '0;
      rdy_prev_q <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
    end else if (!rdy_in) begin
      rdy_prev_q <= 1'b0;
    end else begin
      rdy_prev_q <= 1'b1;
      grant_q    <= '0;
      done_q     <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            port_q   <= pick_idx;
            ptr_q    <= ptr_next;
            addr_q   <= sel_addr;
            n_q      <= sel_n;
            wdata_q  <= sel_wdata;
            k_q      <= '0;
            pend_v_q <= 1'b0;
            grant_q  <= NUM_PORTS'(1) << pick_idx;
            state_q  <= sel_wr ? WRITE : READ;
            if (!sel_wr) rdata_q <= '0;
          end
        end
        READ: begin
          if (flush_in) begin
            state_q  <= IDLE;
            pend_v_q <= 1'b0;
          end else begin
            if (pend_v_q && rdy_prev_q) rdata_q[8*pend_idx_q +: 8] <= mem_din;
            if (rd_issue) begin
              pend_v_q   <= 1'b1;
              pend_idx_q <= byte_idx;
              if (!reissue) k_q <= k_q + 3'd1;
            end else begin
              pend_v_q <= 1'b0;
            end
            // Last byte captured this edge: finish.
            if (!reissue && pend_v_q && (k_q == n_q)) begin
              done_q  <= NUM_PORTS'(1) << port_q;
              state_q <= IDLE;
            end
          end
        end
        WRITE: begin
          if (wr_issue) begin
            k_q <= k_q + 3'd1;
            if (k_q + 3'd1 == n_q) begin
              done_q  <= NUM_PORTS'(1) << port_q;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-exact checks of grant/done timing,
// bus activity, read data, arbitration order, flush, pause, IO stall and reset.
module tb_mem_port_arbiter;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [2:0]  port_req;
  logic [2:0]  port_wr;
  logic [5:0]  port_size;
  logic [95:0] port_addr;
  logic [95:0] port_wdata;
  logic        flush_in;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [2:0]  port_grant;
  logic [2:0]  port_done;
  logic [31:0] rdata;
  logic [1:0]  dbg_state_o;

  int checks   = 0;
  int failures = 0;

  logic        mem_init;
  logic [7:0]  mem [0:1023];
  logic [39:0] exp_q[$];

  mem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .port_req(port_req), .port_wr(port_wr), .port_size(port_size),
    .port_addr(port_addr), .port_wdata(port_wdata),
    .flush_in(flush_in), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .port_grant(port_grant), .port_done(port_done), .rdata(rdata),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      default: return 8'(i) ^ 8'hA5;
    endcase
  endfunction

  function automatic int onehot_idx(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  // synchronous-read byte memory, 1-cycle latency
  always @(posedge clk_in) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_byte(i);
    end else begin
      if (mem_wr) mem[mem_a[9:0]] <= mem_dout;
      mem_din <= mem[mem_a[9:0]];
    end
  end

  // scoreboard: every bus write must match the next expected {addr, data}
  always @(negedge clk_in) begin
    if (mem_wr === 1'b1) begin
      check_eq("wr_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check_eq("wr_byte", 64'({mem_a, mem_dout}), 64'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_port(input int p, input logic req, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
    port_req[p]           = req;
    port_wr[p]            = wr;
    port_size[2*p +: 2]   = sz;
    port_addr[32*p +: 32] = a;
    port_wdata[32*p +: 32] = wd;
  endtask

  int gp[4];
  int gc[4];
  int ng;
  logic [31:0] exp_rd[3];

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; port_req = '0; port_wr = '0; port_size = '0;
    port_addr = '0; port_wdata = '0; flush_in = 1'b0; io_buffer_full = 1'b0;
    mem_init = 1'b1;
    exp_rd[0] = 32'hB5; exp_rd[1] = 32'h85; exp_rd[2] = 32'h95;
    repeat (3) step();
    rst_in = 1'b0; mem_init = 1'b0;

    // reset state
    @(negedge clk_in);
    check_eq("rst_grant", 64'(port_grant), 64'(0));
    check_eq("rst_done", 64'(port_done), 64'(0));
    check_eq("rst_rdata", 64'(rdata), 64'(0));
    check_eq("rst_mem_a", 64'(mem_a), 64'(0));
    check_eq("rst_mem_wr", 64'(mem_wr), 64'(0));
    check_eq("rst_state", 64'(dbg_state_o), 64'(0));
    step();

    // word read, port 1, 0x100
    set_port(1, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
    @(negedge clk_in);
    check_eq("rd_pre_grant", 64'(port_grant), 64'(0));
    step();
    port_req[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      check_eq("rd_grant", 64'(port_grant), 64'(k == 0 ? 3'b010 : 3'b000));
      check_eq("rd_mem_a", 64'(mem_a), 64'(32'h100 + k));
      check_eq("rd_mem_wr", 64'(mem_wr), 64'(0));
      check_eq("rd_no_early_done", 64'(port_done), 64'(0));
      step();
    end
    @(negedge clk_in);
    check_eq("rd_g4_mem_a", 64'(mem_a), 64'(0));
    check_eq("rd_g4_done", 64'(port_done), 64'(0));
    step();
    @(negedge clk_in);
    check_eq("rd_done", 64'(port_done), 64'(3'b010));
    check_eq("rd_rdata", 64'(rdata), 64'(32'h44332211));
    check_eq("rd_done_idle", 64'(dbg_state_o), 64'(0));
    step();

    // round robin from reset: all three ports requesting single-byte reads
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
    set_port(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    set_port(1, 1'b1, 1'b0, 2'b00, 32'h20, 32'h0);
    set_port(2, 1'b1, 1'b0, 2'b00, 32'h30, 32'h0);
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk_in);
      if (port_done != 3'b000) begin
        check_eq("rr_done_onehot", 64'($countones(port_done)), 64'(1));
        check_eq("rr_rdata", 64'(rdata), 64'(exp_rd[onehot_idx(port_done)]));
      end
      if (port_grant != 3'b000) begin
        check_eq("rr_grant_onehot", 64'($countones(port_grant)), 64'(1));
        gp[ng] = onehot_idx(port_grant);
        gc[ng] = c;
        ng++;
      end
      step();
    end
    port_req = '0;
    check_eq("rr_ngrants", 64'(ng), 64'(4));
    if (ng == 4) begin
      check_eq("rr_order0", 64'(gp[0]), 64'(0));
      check_eq("rr_order1", 64'(gp[1]), 64'(1));
      check_eq("rr_order2", 64'(gp[2]), 64'(2));
      check_eq("rr_order3", 64'(gp[3]), 64'(0));
      check_eq("rr_first_latency", 64'(gc[0]), 64'(1));
      for (int i = 1; i < 4; i++) check_eq("rr_gap", 64'(gc[i] - gc[i-1]), 64'(3));
    end
    repeat (4) step();

    // half write to IO region, buffer full for 3 cycles from G
    set_port(2, 1'b1, 1'b1, 2'b01, 32'h30000, 32'h0000_4142);
    exp_q.push_back({32'h30000, 8'h42});
    exp_q.push_back({32'h30001, 8'h41});
    step();
    port_req[2] = 1'b0;
    for (int j = 0; j < 6; j++) begin
      io_buffer_full = (j < 3);
      @(negedge clk_in);
      if (j == 0) check_eq("io_grant", 64'(port_grant), 64'(3'b100));
      check_eq("io_mem_wr", 64'(mem_wr), 64'(j == 3 || j == 4));
      if (j == 3) check_eq("io_byte0", 64'(mem_dout), 64'(8'h42));
      if (j == 4) check_eq("io_byte1", 64'(mem_dout), 64'(8'h41));
      check_eq("io_done", 64'(port_done), 64'(j == 5 ? 3'b100 : 3'b000));
      step();
    end
    io_buffer_full = 1'b0;

    // flush at G+1 of a word read; pending write granted afterwards
    set_port(1, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
    set_port(2, 1'b1, 1'b1, 2'b00, 32'h200, 32'h77);
    exp_q.push_back({32'h200, 8'h77});
    step();
    port_req[1] = 1'b0;
    @(negedge clk_in);
    check_eq("fl_grant", 64'(port_grant), 64'(3'b010));
    step();
    flush_in = 1'b1;
    @(negedge clk_in);
    check_eq("fl_done_g1", 64'(port_done), 64'(0));
    step();
    flush_in = 1'b0;
    @(negedge clk_in);
    check_eq("fl_idle", 64'(dbg_state_o), 64'(0));
    check_eq("fl_done_g2", 64'(port_done), 64'(0));
    step();
    port_req[2] = 1'b0;
    @(negedge clk_in);
    check_eq("fl_wr_grant", 64'(port_grant), 64'(3'b100));
    check_eq("fl_wr_mem_wr", 64'(mem_wr), 64'(1));
    step();
    @(negedge clk_in);
    check_eq("fl_wr_done", 64'(port_done), 64'(3'b100));
    step();

    // flush in IDLE: read on port 0 blocked, write on port 1 accepted
    flush_in = 1'b1;
    set_port(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    set_port(1, 1'b1, 1'b1, 2'b00, 32'h300, 32'h5A);
    exp_q.push_back({32'h300, 8'h5A});
    step();
    flush_in = 1'b0;
    port_req[1] = 1'b0;
    @(negedge clk_in);
    check_eq("fi_grant_write", 64'(port_grant), 64'(3'b010));
    step();
    @(negedge clk_in);
    check_eq("fi_wr_done", 64'(port_done), 64'(3'b010));
    step();
    @(negedge clk_in);
    check_eq("fi_read_grant", 64'(port_grant), 64'(3'b001));
    step();
    port_req[0] = 1'b0;
    step();
    @(negedge clk_in);
    check_eq("fi_read_done", 64'(port_done), 64'(3'b001));
    check_eq("fi_read_rdata", 64'(rdata), 64'(32'hB5));
    step();

    // pause for 2 cycles at G+1 of a word read
    set_port(1, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
    step();
    port_req[1] = 1'b0;
    @(negedge clk_in);
    check_eq("ps_grant", 64'(port_grant), 64'(3'b010));
    step();
    rdy_in = 1'b0;
    for (int j = 1; j < 3; j++) begin
      @(negedge clk_in);
      check_eq("ps_mem_wr", 64'(mem_wr), 64'(0));
      check_eq("ps_no_done", 64'(port_done), 64'(0));
      step();
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    check_eq("ps_reissue", 64'(mem_a), 64'(32'h100));
    step();
    for (int j = 4; j < 9; j++) begin
      @(negedge clk_in);
      if (j == 4) check_eq("ps_next_byte", 64'(mem_a), 64'(32'h101));
      check_eq("ps_done", 64'(port_done), 64'(j == 8 ? 3'b010 : 3'b000));
      if (j == 8) check_eq("ps_rdata", 64'(rdata), 64'(32'h44332211));
      step();
    end

    // reset at G+2 of a word write
    set_port(1, 1'b1, 1'b1, 2'b10, 32'h40, 32'hDDCC_BBAA);
    exp_q.push_back({32'h40, 8'hAA});
    exp_q.push_back({32'h41, 8'hBB});
    step();
    port_req[1] = 1'b0;
    set_port(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    set_port(2, 1'b1, 1'b0, 2'b00, 32'h20, 32'h0);
    @(negedge clk_in);
    check_eq("rs_grant", 64'(port_grant), 64'(3'b010));
    check_eq("rs_byte0", 64'(mem_dout), 64'(8'hAA));
    step();
    @(negedge clk_in);
    check_eq("rs_byte1", 64'(mem_dout), 64'(8'hBB));
    step();
    rst_in = 1'b1;
    @(negedge clk_in);
    step();
    rst_in = 1'b0;
    @(negedge clk_in);
    check_eq("rs_grant0", 64'(port_grant), 64'(0));
    check_eq("rs_done0", 64'(port_done), 64'(0));
    check_eq("rs_rdata0", 64'(rdata), 64'(0));
    check_eq("rs_mem_a0", 64'(mem_a), 64'(0));
    check_eq("rs_dout0", 64'(mem_dout), 64'(0));
    check_eq("rs_mem_wr0", 64'(mem_wr), 64'(0));
    check_eq("rs_state0", 64'(dbg_state_o), 64'(0));
    step();
    @(negedge clk_in);
    check_eq("rs_next_grant_p0", 64'(port_grant), 64'(3'b001));
    step();
    port_req[0] = 1'b0;
    @(negedge clk_in);
    check_eq("rs_no_stale_done", 64'(port_done), 64'(0));
    step();
    @(negedge clk_in);
    check_eq("rs_p0_done", 64'(port_done), 64'(3'b001));
    check_eq("rs_p0_rdata", 64'(rdata), 64'(32'hB5));
    step();
    @(negedge clk_in);
    check_eq("rs_p2_grant", 64'(port_grant), 64'(3'b100));
    step();
    port_req[2] = 1'b0;
    repeat (4) step();

    check_eq("wr_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
